// File: rtl/accum_buffer_pkg.sv
// Shared types, parameter defaults and the per-lane saturating adder for accum_buffer.
package accum_buffer_pkg;

    localparam int N_COLS_DEFAULT = 2;
    localparam int COL_W_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT  = 256;

    // Lanes are sign-extended to this width before a saturating add, so any
    // COL_W up to SAT_W-1 bits can be clamped without intermediate overflow.
    localparam int SAT_W = 64;

    typedef logic signed [COL_W_DEFAULT-1:0] lane_t;
    typedef lane_t [N_COLS_DEFAULT-1:0]      entry_t;
    typedef logic signed [SAT_W-1:0]         wide_lane_t;

    typedef enum logic {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } swap_state_e;

    // Adds two sign-extended lanes and clamps the result to a w-bit signed range.
    function automatic wide_lane_t sat_add(input wide_lane_t a, input wide_lane_t b,
                                           input int unsigned w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] max_v;
        logic signed [SAT_W:0] min_v;
        logic signed [SAT_W:0] one;
        one   = (SAT_W+1)'(1);
        sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        max_v = (one <<< (w - 1)) - one;
        min_v = -max_v - one;
        if (sum > max_v) begin
            return max_v[SAT_W-1:0];
        end else if (sum < min_v) begin
            return min_v[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/acc_bank_ram.sv
// One accumulation bank: simple dual-port RAM, one write port, one registered read port.
module acc_bank_ram
    import accum_buffer_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; the read register only updates on re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/accum_buffer.sv
// Double-banked accumulation buffer: the array drain writes (overwrite or accumulate)
// into the active bank while the other bank is read out; a swap exchanges roles.
// Optional build macro: ACCUM_BUFFER_SAT_EN makes accumulation saturate per lane
// instead of wrapping.
//
// state   | meaning
// SW_IDLE | no swap outstanding, writes accepted
// SW_PEND | swap requested, writes stalled until commit stage and reads are idle
module accum_buffer
    import accum_buffer_pkg::*;
#(
    parameter int N_COLS  = N_COLS_DEFAULT,
    parameter int COL_W   = COL_W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int DATA_W = N_COLS * COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_accum,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              active_bank
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    swap_state_e       state_q, state_d;
    logic              active_bank_q, active_bank_d;
    logic              swap_ack_q, swap_ack_d;
    logic              swap_fire;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_accum_q, s2_accum_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_oob_q, rd_oob_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

    logic              wr_fire;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] old_entry;
    logic [DATA_W-1:0] commit_data;
    logic [DATA_W-1:0] ram_rdata [2];

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
    assign wr_ready    = (state_q == SW_IDLE);
    assign wr_fire     = wr_valid && wr_ready;

    // Swap control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SW_IDLE;
            active_bank_q <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            swap_ack_q    <= swap_ack_d;
        end
    end

    // Swap waits for the commit stage to drain and for a read-free edge so no
    // in-flight access ever straddles the bank change.
    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        swap_ack_d    = 1'b0;
        swap_fire     = 1'b0;
        case (state_q)
            SW_IDLE: begin
                if (swap_req) begin
                    state_d = SW_PEND;
                end
            end
            SW_PEND: begin
                if (!s2_valid_q && !rd_en) begin
                    swap_fire     = 1'b1;
                    state_d       = SW_IDLE;
                    active_bank_d = !active_bank_q;
                    swap_ack_d    = 1'b1;
                end
            end
            default: state_d = SW_IDLE;
        endcase
    end

    // Commit value: old entry comes from the forward register when the previous
    // commit hit the same address, since the RAM read raced that write.
    always_comb begin
        old_entry   = fwd_valid_q ? fwd_data_q : ram_rdata[active_bank_q];
        commit_data = s2_data_q;
        if (s2_accum_q) begin
            for (int i = 0; i < N_COLS; i++) begin
`ifdef ACCUM_BUFFER_SAT_EN
                commit_data[i*COL_W +: COL_W] = COL_W'(sat_add(
                    SAT_W'($signed(old_entry[i*COL_W +: COL_W])),
                    SAT_W'($signed(s2_data_q[i*COL_W +: COL_W])),
                    COL_W));
`else
                commit_data[i*COL_W +: COL_W] = old_entry[i*COL_W +: COL_W]
                                              + s2_data_q[i*COL_W +: COL_W];
`endif
            end
        end
    end

    // Read output: live RAM data the cycle after rd_en, otherwise the held value.
    always_comb begin
        rd_data = rd_hold_q;
        if (rd_valid_q) begin
            rd_data = rd_oob_q ? '0 : ram_rdata[!active_bank_q];
        end
    end

    // Next-state for the write pipeline and read tracking.
    always_comb begin
        s2_valid_d = wr_fire && wr_in_range;
        s2_accum_d = s2_accum_q;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        if (wr_fire) begin
            s2_accum_d = wr_accum;
            s2_addr_d  = wr_addr;
            s2_data_d  = wr_data;
        end
        fwd_valid_d = s2_valid_d && s2_valid_q && (wr_addr == s2_addr_q);
        fwd_data_d  = commit_data;
        rd_valid_d  = rd_en;
        rd_oob_d    = rd_en ? !rd_in_range : rd_oob_q;
        rd_hold_d   = rd_data;
    end

    // Pipeline and read registers; clearing s2_valid on reset discards a pending commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_accum_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_data_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_oob_q    <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            s2_valid_q  <= s2_valid_d;
            s2_accum_q  <= s2_accum_d;
            s2_addr_q   <= s2_addr_d;
            s2_data_q   <= s2_data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_oob_q    <= rd_oob_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    // Active bank serves the write pipeline (its read port fetches the old entry);
    // the inactive bank serves external reads.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic is_active;
        assign is_active = (active_bank_q == 1'(g));
        acc_bank_ram #(
            .WIDTH  (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (s2_valid_q && is_active),
            .waddr (s2_addr_q),
            .wdata (commit_data),
            .re    (is_active ? s2_valid_d : (rd_en && rd_in_range)),
            .raddr (is_active ? wr_addr : rd_addr),
            .rdata (ram_rdata[g])
        );
    end

    assign rd_valid    = rd_valid_q;
    assign swap_ack    = swap_ack_q;
    assign active_bank = active_bank_q;

endmodule

// File: tb/tb_accum_buffer.sv
// Directed bench for accum_buffer (N_COLS=2, COL_W=8, DEPTH=200).
module tb_accum_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_accum = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        active_bank;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]        addr;
        logic signed [7:0] ov1, ov0, ac1, ac0;
        logic signed [7:0] ew1, ew0, es1, es0;
    } vec_t;

    vec_t tbl [5];

    accum_buffer #(.N_COLS(2), .COL_W(8), .DEPTH(200)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_accum    (wr_accum),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .active_bank (active_bank)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pk(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic write_beat(input logic acc, input logic [7:0] addr, input logic [15:0] data);
        wr_valid = 1'b1;
        wr_accum = acc;
        wr_addr  = addr;
        wr_data  = data;
        tick();
    endtask

    // Garbage on the bus with wr_valid low must never reach memory.
    task automatic wr_idle();
        wr_valid = 1'b0;
        wr_accum = 1'b1;
        wr_data  = 16'hA5A5;
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        chk1({name, "_valid"}, rd_valid, 1'b1);
        chk16({name, "_data"}, rd_data, exp);
        tick();
        chk1({name, "_valid_low"}, rd_valid, 1'b0);
        chk16({name, "_hold"}, rd_data, exp);
    endtask

    task automatic do_swap(input logic exp_bank);
        logic got;
        got = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (swap_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk1("swap_ack_seen", got, 1'b1);
        chk1("swap_bank", active_bank, exp_bank);
        tick();
        chk1("swap_ack_pulse", swap_ack, 1'b0);
    endtask

    initial begin
        logic [15:0] exp;

        //          addr    ov1     ov0      ac1     ac0      wrap         sat
        tbl[0] = '{8'd5,   8'sd2,   8'sd1,  8'sd3,   8'sd4,   8'sd5,   8'sd5,   8'sd5,   8'sd5};
        tbl[1] = '{8'd17,  8'sd100, -8'sd100, 8'sd100, -8'sd100, -8'sd56, 8'sd56, 8'sd127, -8'sd128};
        tbl[2] = '{8'd199, -8'sd1,  8'sd127, 8'sd1,   8'sd1,   8'sd0,   -8'sd128, 8'sd0,  8'sd127};
        tbl[3] = '{8'd42,  -8'sd128, 8'sd0,  -8'sd1,  -8'sd1,  8'sd127, -8'sd1,  -8'sd128, -8'sd1};
        tbl[4] = '{8'd7,   8'sd10,  8'sd20, -8'sd30,  8'sd5,  -8'sd20,  8'sd25, -8'sd20,  8'sd25};

        // Reset values while rst_n is held low, before any clock edge.
        #3;
        chk1("rst_active_bank", active_bank, 1'b0);
        chk1("rst_wr_ready", wr_ready, 1'b1);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk16("rst_rd_data", rd_data, 16'h0000);
        chk1("rst_swap_ack", swap_ack, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Bank 0: overwrite then back-to-back accumulate per table entry.
        for (int i = 0; i < 5; i++) begin
            write_beat(1'b0, tbl[i].addr, pk(tbl[i].ov1, tbl[i].ov0));
            write_beat(1'b1, tbl[i].addr, pk(tbl[i].ac1, tbl[i].ac0));
            wr_idle();
            tick();
        end
        do_swap(1'b1);
        for (int i = 0; i < 5; i++) begin
`ifdef ACCUM_BUFFER_SAT_EN
            exp = pk(tbl[i].es1, tbl[i].es0);
`else
            exp = pk(tbl[i].ew1, tbl[i].ew0);
`endif
            do_read($sformatf("tbl%0d", i), tbl[i].addr, exp);
        end

        // Bank 1: four full-rate accumulates to one address, plus an out-of-range write.
        write_beat(1'b0, 8'd0, pk(8'd0, 8'd0));
        for (int i = 0; i < 4; i++) write_beat(1'b1, 8'd0, pk(8'd1, 8'd1));
        write_beat(1'b0, 8'd50, pk(8'd9, 8'd9));
        write_beat(1'b0, 8'd250, pk(8'd77, 8'd77));
        write_beat(1'b1, 8'd250, pk(8'd1, 8'd1));
        wr_idle();
        tick();

        // Swap requested alongside a write, with rd_en held for three edges.
        wr_valid = 1'b1;
        wr_accum = 1'b0;
        wr_addr  = 8'd60;
        wr_data  = pk(8'd3, 8'd3);
        swap_req = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 8'd5;
        chk1("c_ready_pre", wr_ready, 1'b1);
        tick();
        chk1("c_ready_pending", wr_ready, 1'b0);
        chk1("c_rdv_0", rd_valid, 1'b1);
        chk16("c_rdd_0", rd_data, pk(8'd5, 8'd5));
        chk1("c_ack_0", swap_ack, 1'b0);
        wr_idle();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk1("c_ack_1", swap_ack, 1'b0);
        chk1("c_ready_1", wr_ready, 1'b0);
        tick();
        chk1("c_ack_2", swap_ack, 1'b0);
        chk1("c_bank_2", active_bank, 1'b1);
        rd_en = 1'b0;
        tick();
        chk1("c_ack_3", swap_ack, 1'b1);
        chk1("c_bank_3", active_bank, 1'b0);
        chk1("c_ready_3", wr_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("c_ack_after%0d", i), swap_ack, 1'b0);
            chk1($sformatf("c_bank_after%0d", i), active_bank, 1'b0);
        end

        // Read back bank 1.
        do_read("fwd_addr0", 8'd0, pk(8'd4, 8'd4));
        do_read("addr50", 8'd50, pk(8'd9, 8'd9));
        do_read("addr60", 8'd60, pk(8'd3, 8'd3));
        do_read("addr250", 8'd250, 16'h0000);

        // Reset in the middle of an accumulate to bank 1 addr 60.
        do_swap(1'b1);
        do_read("e_pre", 8'd5, pk(8'd5, 8'd5));
        wr_valid = 1'b1;
        wr_accum = 1'b1;
        wr_addr  = 8'd60;
        wr_data  = pk(8'd1, 8'd1);
        rd_en    = 1'b1;
        rd_addr  = 8'd7;
        tick();
        chk1("e_rdv_before", rd_valid, 1'b1);
        chk16("e_rdd_before", rd_data, pk(-8'sd20, 8'sd25));
        wr_idle();
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("e_bank", active_bank, 1'b0);
        chk1("e_rdv", rd_valid, 1'b0);
        chk16("e_rdd", rd_data, 16'h0000);
        chk1("e_ack", swap_ack, 1'b0);
        chk1("e_ready", wr_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk1("e_bank_release", active_bank, 1'b0);
        chk16("e_rdd_release", rd_data, 16'h0000);
        tick();
        do_read("e_entry", 8'd60, pk(8'd3, 8'd3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
